// File: rtl/data_mem_access.sv
// Byte-addressable big-endian data memory for the MEM stage.
// Size-aware store formatting, combinational size-aware loads with
// sign/zero extension. Sub-blocks: dmem, extender, mux_4to1_n.

// 4:1 selector of N-bit values.
module mux_4to1_n #(
    parameter int N = 32
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [N-1:0] out
);
    // Plain binary-coded select.
    always_comb begin
        out = in0;
        case (sel)
            2'b00: out = in0;
            2'b01: out = in1;
            2'b10: out = in2;
            2'b11: out = in3;
            default: out = in0;
        endcase
    end
endmodule

// Extends an IN_W-bit value to 32 bits, signed or unsigned.
module extender #(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] din,
    input  logic            signExt,
    output logic [31:0]     dout
);
    assign dout = {{(32-IN_W){signExt & din[IN_W-1]}}, din};
endmodule

// SIZE-byte array with async clear; reads return the byte, aligned
// halfword and aligned word around ea, all right-justified.
module dmem #(
    parameter int SIZE = 16384,
    localparam int AW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ea,
    input  logic [31:0]   storeData,
    input  logic          memWr,
    input  logic [1:0]    dsize,
    output logic [31:0]   byteRaw,
    output logic [31:0]   halfRaw,
    output logic [31:0]   wordRaw
);
    logic [7:0]    mem [SIZE];
    logic [AW-1:0] halfBase;
    logic [AW-1:0] wordBase;

    // Alignment is done by masking so it stays valid down to SIZE = 4.
    assign halfBase = ea & ~AW'(1);
    assign wordBase = ea & ~AW'(3);

    assign byteRaw = {24'b0, mem[ea]};
    assign halfRaw = {16'b0, mem[halfBase], mem[halfBase + AW'(1)]};
    assign wordRaw = {mem[wordBase], mem[wordBase + AW'(1)],
                      mem[wordBase + AW'(2)], mem[wordBase + AW'(3)]};

    // Async clear; otherwise write only the bytes the access covers, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (memWr) begin
            case (dsize)
                2'b00: mem[ea] <= storeData[7:0];
                2'b01: begin
                    mem[halfBase]          <= storeData[15:8];
                    mem[halfBase + AW'(1)] <= storeData[7:0];
                end
                2'b11: begin
                    mem[wordBase]          <= storeData[31:24];
                    mem[wordBase + AW'(1)] <= storeData[23:16];
                    mem[wordBase + AW'(2)] <= storeData[15:8];
                    mem[wordBase + AW'(3)] <= storeData[7:0];
                end
                default: ;
            endcase
        end
    end
endmodule

module data_mem_access #(
    parameter int SIZE = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic [1:0]  dsize,
    input  logic        loadext,
    output logic [31:0] raw_data,
    output logic [31:0] load_data
);
    localparam int AW = $clog2(SIZE);

    logic [AW-1:0]   ea;
    logic [31-AW:0]  unusedAddrHi;
    logic [31:0]     storeData;
    logic [31:0]     byteRaw;
    logic [31:0]     halfRaw;
    logic [31:0]     wordRaw;
    logic [31:0]     ext8Data;
    logic [31:0]     ext16Data;

    // Only the low log2(SIZE) address bits select a byte; the rest wrap.
    assign ea           = addr[AW-1:0];
    assign unusedAddrHi = addr[31:AW];

    mux_4to1_n #(.N(32)) uStoreMux (
        .sel (dsize),
        .in0 ({24'b0, wdata[7:0]}),
        .in1 ({16'b0, wdata[15:0]}),
        .in2 (32'b0),
        .in3 (wdata),
        .out (storeData)
    );

    dmem #(.SIZE(SIZE)) uDmem (
        .clk       (clk),
        .rst_n     (rst_n),
        .ea        (ea),
        .storeData (storeData),
        .memWr     (mem_wr),
        .dsize     (dsize),
        .byteRaw   (byteRaw),
        .halfRaw   (halfRaw),
        .wordRaw   (wordRaw)
    );

    mux_4to1_n #(.N(32)) uRawMux (
        .sel (dsize),
        .in0 (byteRaw),
        .in1 (halfRaw),
        .in2 (32'b0),
        .in3 (wordRaw),
        .out (raw_data)
    );

    extender #(.IN_W(8)) uExt8 (
        .din     (raw_data[7:0]),
        .signExt (loadext),
        .dout    (ext8Data)
    );

    extender #(.IN_W(16)) uExt16 (
        .din     (raw_data[15:0]),
        .signExt (loadext),
        .dout    (ext16Data)
    );

    mux_4to1_n #(.N(32)) uLoadMux (
        .sel (dsize),
        .in0 (ext8Data),
        .in1 (ext16Data),
        .in2 (32'b0),
        .in3 (raw_data),
        .out (load_data)
    );
endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed vector table, hand-written reset and
// read-before-write sequences, and random accesses against a byte-array model.
module tb_data_mem_access;
    localparam int SIZE = 16384;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic [1:0]  dsize;
    logic        loadext;
    logic [31:0] raw_data;
    logic [31:0] load_data;

    int vecCount = 0;
    int errCount = 0;

    logic [7:0] refMem [SIZE];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        memWr;
        logic [1:0]  dsize;
        logic        loadext;
        logic [31:0] expRaw;
        logic [31:0] expLoad;
    } vec_t;

    vec_t vecs[$];

    data_mem_access #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .mem_wr    (mem_wr),
        .dsize     (dsize),
        .loadext   (loadext),
        .raw_data  (raw_data),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRaw(input logic [31:0] a, input logic [1:0] sz);
        int e;
        int b;
        e = int'(a % SIZE);
        case (sz)
            2'b00: return {24'b0, refMem[e]};
            2'b01: begin
                b = e - (e % 2);
                return {16'b0, refMem[b], refMem[b+1]};
            end
            2'b11: begin
                b = e - (e % 4);
                return {refMem[b], refMem[b+1], refMem[b+2], refMem[b+3]};
            end
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic se);
        logic [31:0] r;
        r = modelRaw(a, sz);
        case (sz)
            2'b00: return (se && r[7])  ? (r | 32'hFFFF_FF00) : r;
            2'b01: return (se && r[15]) ? (r | 32'hFFFF_0000) : r;
            2'b11: return r;
            default: return 32'b0;
        endcase
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int e;
        int b;
        e = int'(a % SIZE);
        case (sz)
            2'b00: refMem[e] = d[7:0];
            2'b01: begin
                b = e - (e % 2);
                refMem[b]   = d[15:8];
                refMem[b+1] = d[7:0];
            end
            2'b11: begin
                b = e - (e % 4);
                refMem[b]   = d[31:24];
                refMem[b+1] = d[23:16];
                refMem[b+2] = d[15:8];
                refMem[b+3] = d[7:0];
            end
            default: ;
        endcase
    endtask

    task automatic modelClear();
        for (int i = 0; i < SIZE; i++) refMem[i] = 8'h00;
    endtask

    // Drive one access in the low phase, check outputs before the edge,
    // then let the edge commit any write.
    task automatic runVec(input vec_t v);
        @(negedge clk);
        addr    = v.addr;
        wdata   = v.wdata;
        mem_wr  = v.memWr;
        dsize   = v.dsize;
        loadext = v.loadext;
        #1;
        check({v.name, " raw"},  raw_data,  v.expRaw);
        check({v.name, " load"}, load_data, v.expLoad);
        if (v.memWr) modelWrite(v.addr, v.wdata, v.dsize);
    endtask

    initial begin
        vec_t v;
        modelClear();

        // Writes held during reset must be suppressed.
        rst_n = 1'b0; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        mem_wr = 1'b1; dsize = 2'b11; loadext = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_suppressed", raw_data, 32'h0);

        // Release mid-cycle: the very next edge must write.
        @(negedge clk);
        rst_n = 1'b1; addr = 32'h8; wdata = 32'h1122_3344;
        #1;
        check("rst_release_pre", raw_data, 32'h0);
        @(posedge clk);
        #1;
        check("rst_release_first_wr", raw_data, 32'h1122_3344);
        modelWrite(32'h8, 32'h1122_3344, 2'b11);

        vecs.push_back('{"rd0_after_rst",   32'h0000_0000, 32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rd_top_after_rst",SIZE-4,        32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"st_w10",          32'h10, 32'h8899_AABC, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"ld_w10",          32'h10, 32'h0, 1'b0, 2'b11, 1'b1, 32'h8899_AABC, 32'h8899_AABC});
        vecs.push_back('{"ld_b10_s",        32'h10, 32'h0, 1'b0, 2'b00, 1'b1, 32'h88, 32'hFFFF_FF88});
        vecs.push_back('{"ld_b13_s",        32'h13, 32'h0, 1'b0, 2'b00, 1'b1, 32'hBC, 32'hFFFF_FFBC});
        vecs.push_back('{"ld_b10_z",        32'h10, 32'h0, 1'b0, 2'b00, 1'b0, 32'h88, 32'h88});
        vecs.push_back('{"ld_b13_z",        32'h13, 32'h0, 1'b0, 2'b00, 1'b0, 32'hBC, 32'hBC});
        vecs.push_back('{"ld_h12_s",        32'h12, 32'h0, 1'b0, 2'b01, 1'b1, 32'hAABC, 32'hFFFF_AABC});
        vecs.push_back('{"st_b11",          32'h11, 32'h1234_5677, 1'b1, 2'b00, 1'b0, 32'h99, 32'h99});
        vecs.push_back('{"ld_w10_b",        32'h10, 32'h0, 1'b0, 2'b11, 1'b0, 32'h8877_AABC, 32'h8877_AABC});
        vecs.push_back('{"st_h13",          32'h13, 32'hFFFF_0102, 1'b1, 2'b01, 1'b0, 32'hAABC, 32'hAABC});
        vecs.push_back('{"ld_w10_h",        32'h10, 32'h0, 1'b0, 2'b11, 1'b0, 32'h8877_0102, 32'h8877_0102});
        vecs.push_back('{"rsv_wr",          32'h10, 32'hFFFF_FFFF, 1'b1, 2'b10, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{"ld_w10_rsv",      32'h10, 32'h0, 1'b0, 2'b11, 1'b0, 32'h8877_0102, 32'h8877_0102});
        vecs.push_back('{"st_wrap",         SIZE+32'h20, 32'hDEAD_BEEF, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"ld_w20",          32'h20, 32'h0, 1'b0, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{"nowr",            32'h20, 32'h1234_5678, 1'b0, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{"ld_w20_nowr",     32'h20, 32'h0, 1'b0, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{"ld_h21_s",        32'h21, 32'h0, 1'b0, 2'b01, 1'b1, 32'hDEAD, 32'hFFFF_DEAD});
        vecs.push_back('{"ld_h22_z",        32'h22, 32'h0, 1'b0, 2'b01, 1'b0, 32'hBEEF, 32'hBEEF});
        vecs.push_back('{"ld_w8",           32'hB, 32'h0, 1'b0, 2'b11, 1'b0, 32'h1122_3344, 32'h1122_3344});

        foreach (vecs[i]) runVec(vecs[i]);

        // Read-before-write at 0x40: old contents before the edge, new after.
        @(negedge clk);
        addr = 32'h40; wdata = 32'h0102_0304; mem_wr = 1'b1; dsize = 2'b11; loadext = 1'b0;
        #1;
        check("rbw_before", load_data, 32'h0);
        @(posedge clk);
        #1;
        check("rbw_after", load_data, 32'h0102_0304);
        modelWrite(32'h40, 32'h0102_0304, 2'b11);

        // Random accesses concentrated on a small window so reads hit writes.
        for (int n = 0; n < 400; n++) begin
            v.name    = "rand";
            v.addr    = $urandom & 32'hFFFF_C0FF;
            v.wdata   = $urandom;
            v.memWr   = ($urandom_range(0, 1) == 1);
            v.dsize   = 2'($urandom_range(0, 3));
            v.loadext = 1'($urandom_range(0, 1));
            v.expRaw  = modelRaw(v.addr, v.dsize);
            v.expLoad = modelLoad(v.addr, v.dsize, v.loadext);
            runVec(v);
        end

        // Fill both ends, then pulse reset between edges and confirm clear.
        runVec('{"fill_lo", 32'h0,   32'hA5A5_A5A5, 1'b1, 2'b11, 1'b0,
                 modelRaw(32'h0, 2'b11), modelLoad(32'h0, 2'b11, 1'b0)});
        runVec('{"fill_hi", SIZE-4,  32'h5A5A_5A5A, 1'b1, 2'b11, 1'b0,
                 modelRaw(SIZE-4, 2'b11), modelLoad(SIZE-4, 2'b11, 1'b0)});
        runVec('{"filled_lo", 32'h0, 32'h0, 1'b0, 2'b11, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
        @(negedge clk);
        mem_wr = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        modelClear();
        #1;
        check("pulse_rst_lo", raw_data, 32'h0);
        runVec('{"pulse_rst_hi", SIZE-4, 32'h0, 1'b0, 2'b11, 1'b1, 32'h0, 32'h0});
        runVec('{"pulse_rst_lo_b", 32'h3, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
